// File: rtl/lda_line_engine_pkg.sv
// Shared types and width helpers for the Bresenham line engine.
package lda_pkg;

   localparam int LDA_XW = 9;
   localparam int LDA_YW = 9;
   localparam int LDA_CW = 3;

   function automatic int lda_width(input int xw, input int yw);
      return ((xw > yw) ? xw : yw) + 2;
   endfunction

   // Signed width of dx/dy/err/e2: e2 = 2*err must fit without overflow.
   localparam int LDA_W = lda_width(LDA_XW, LDA_YW);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      DONE = 2'd2
   } lda_state_t;

   typedef struct packed {
      logic [LDA_XW-1:0] x0;
      logic [LDA_YW-1:0] y0;
      logic [LDA_XW-1:0] x1;
      logic [LDA_YW-1:0] y1;
      logic [LDA_CW-1:0] color;
   } lda_cmd_t;

endpackage

// File: rtl/lda_line_engine_step.sv
// One Bresenham step: next point and error term from the current ones.
module lda_step
   import lda_pkg::*;
#(
   parameter int XW = 9,
   parameter int YW = 9,
   parameter int W  = lda_width(XW, YW)
) (
   input  logic [XW-1:0]        x,
   input  logic [YW-1:0]        y,
   input  logic signed [W-1:0]  err,
   input  logic signed [W-1:0]  dx,
   input  logic signed [W-1:0]  dy,
   input  logic                 right,
   input  logic                 down,
   output logic [XW-1:0]        x_nxt,
   output logic [YW-1:0]        y_nxt,
   output logic signed [W-1:0]  err_nxt
);

   localparam logic [XW-1:0] X_ONE = XW'(1);
   localparam logic [YW-1:0] Y_ONE = YW'(1);

   logic signed [W-1:0] e2;

   // Both tests use the pre-step e2; the two err increments accumulate.
   always_comb begin
      e2      = err <<< 1;
      x_nxt   = x;
      y_nxt   = y;
      err_nxt = err;
      if (e2 >= dy) begin
         err_nxt = err_nxt + dy;
         x_nxt   = right ? x + X_ONE : x - X_ONE;
      end
      if (e2 <= dx) begin
         err_nxt = err_nxt + dx;
         y_nxt   = down ? y + Y_ONE : y - Y_ONE;
      end
   end

endmodule

// File: rtl/lda_line_engine.sv
// Bresenham line engine: command in, back-pressured pixel stream out, done pulse.
// Define LDA_CLIP_EN to suppress pixels outside H_RES x V_RES.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// DRAW  | presenting / stepping through line points
// DONE  | one-cycle o_done pulse, then back to IDLE
module lda_line_engine
   import lda_pkg::*;
#(
   parameter int XW    = 9,
   parameter int YW    = 9,
   parameter int CW    = 3,
   parameter int H_RES = 320,
   parameter int V_RES = 240
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [XW-1:0] X0,
   input  logic [YW-1:0] Y0,
   input  logic [XW-1:0] X1,
   input  logic [YW-1:0] Y1,
   input  logic [CW-1:0] COLOR,
   input  logic          i_abort,
   output logic          o_valid,
   input  logic          i_ready,
   output logic [XW-1:0] o_X,
   output logic [YW-1:0] o_Y,
   output logic [CW-1:0] o_COLOR,
   output logic          o_done,
   output logic          o_busy
);

   localparam int W = lda_width(XW, YW);

`ifdef LDA_CLIP_EN
   localparam bit CLIP_EN = 1'b1;
`else
   localparam bit CLIP_EN = 1'b0;
`endif

   localparam logic [XW:0] H_LIM = (XW+1)'(H_RES);
   localparam logic [YW:0] V_LIM = (YW+1)'(V_RES);

   function automatic logic on_screen(input logic [XW-1:0] x, input logic [YW-1:0] y);
      return !CLIP_EN || (({1'b0, x} < H_LIM) && ({1'b0, y} < V_LIM));
   endfunction

   lda_state_t          state_q, state_d;
   logic [XW-1:0]       x_q, x_d, x1_q, x1_d;
   logic [YW-1:0]       y_q, y_d, y1_q, y1_d;
   logic [CW-1:0]       color_q, color_d;
   logic signed [W-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
   logic                right_q, right_d, down_q, down_d;
   logic                valid_q, valid_d, done_q, done_d;
   logic                ready_q, ready_d, busy_q, busy_d;

   logic [XW-1:0]       x_step, adx;
   logic [YW-1:0]       y_step, ady;
   logic signed [W-1:0] err_step, dx_new, dy_new;
   logic                right_new, down_new, at_end;

   lda_step #(.XW(XW), .YW(YW), .W(W)) u_step (
      .x       (x_q),
      .y       (y_q),
      .err     (err_q),
      .dx      (dx_q),
      .dy      (dy_q),
      .right   (right_q),
      .down    (down_q),
      .x_nxt   (x_step),
      .y_nxt   (y_step),
      .err_nxt (err_step)
   );

   always_comb begin
      right_new = (X1 >= X0);
      down_new  = (Y1 >= Y0);
      adx       = right_new ? X1 - X0 : X0 - X1;
      ady       = down_new  ? Y1 - Y0 : Y0 - Y1;
      dx_new    = $signed({{(W-XW){1'b0}}, adx});
      dy_new    = -$signed({{(W-YW){1'b0}}, ady});
      at_end    = (x_q == x1_q) && (y_q == y1_q);
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      x1_d    = x1_q;
      y1_d    = y1_q;
      color_d = color_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      err_d   = err_q;
      right_d = right_q;
      down_d  = down_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      ready_d = ready_q;
      busy_d  = busy_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               state_d = DRAW;
               x_d     = X0;
               y_d     = Y0;
               x1_d    = X1;
               y1_d    = Y1;
               color_d = COLOR;
               dx_d    = dx_new;
               dy_d    = dy_new;
               err_d   = dx_new + dy_new;
               right_d = right_new;
               down_d  = down_new;
               valid_d = on_screen(X0, Y0);
               ready_d = 1'b0;
               busy_d  = 1'b1;
            end
         end
         DRAW: begin
            if (i_abort) begin
               state_d = IDLE;
               valid_d = 1'b0;
               ready_d = 1'b1;
               busy_d  = 1'b0;
            end else if (!valid_q || i_ready) begin
               // A hidden (clipped) point advances without waiting for the sink.
               if (at_end) begin
                  state_d = DONE;
                  valid_d = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  x_d     = x_step;
                  y_d     = y_step;
                  err_d   = err_step;
                  valid_d = on_screen(x_step, y_step);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            ready_d = 1'b1;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
            ready_d = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         x1_q    <= '0;
         y1_q    <= '0;
         color_q <= '0;
         dx_q    <= '0;
         dy_q    <= '0;
         err_q   <= '0;
         right_q <= 1'b0;
         down_q  <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         x1_q    <= x1_d;
         y1_q    <= y1_d;
         color_q <= color_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         err_q   <= err_d;
         right_q <= right_d;
         down_q  <= down_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   assign cmd_ready = ready_q;
   assign o_valid   = valid_q;
   assign o_X       = x_q;
   assign o_Y       = y_q;
   assign o_COLOR   = color_q;
   // An abort landing in DONE swallows the pulse.
   assign o_done    = done_q & ~i_abort;
   assign o_busy    = busy_q;

endmodule

// File: tb/tb_lda_line_engine.sv
// Self-checking bench for lda_line_engine against a queue-based Bresenham model.
module tb_lda_line_engine;
   import lda_pkg::*;

   localparam int XW = 9, YW = 9, CW = 3, H_RES = 320, V_RES = 240;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          cmd_valid = 1'b0, i_abort = 1'b0, i_ready = 1'b0;
   logic          cmd_ready, o_valid, o_done, o_busy;
   logic [XW-1:0] X0 = '0, X1 = '0, o_X;
   logic [YW-1:0] Y0 = '0, Y1 = '0, o_Y;
   logic [CW-1:0] COLOR = '0, o_COLOR;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {int x; int y;} pt_t;
   pt_t exp_q[$];
   int  ref_len;
   bit  ref_first_on, ref_last_on;

   always #5 clk = ~clk;

   lda_line_engine #(.XW(XW), .YW(YW), .CW(CW), .H_RES(H_RES), .V_RES(V_RES)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .X0(X0), .Y0(Y0), .X1(X1), .Y1(Y1), .COLOR(COLOR), .i_abort(i_abort),
      .o_valid(o_valid), .i_ready(i_ready), .o_X(o_X), .o_Y(o_Y), .o_COLOR(o_COLOR),
      .o_done(o_done), .o_busy(o_busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic bit visible(input int x, input int y);
`ifdef LDA_CLIP_EN
      return (x < H_RES) && (y < V_RES);
`else
      return 1'b1;
`endif
   endfunction

   function automatic lda_cmd_t mk(input int x0, input int y0, input int x1, input int y1, input int col);
      lda_cmd_t c;
      c.x0 = XW'(x0); c.y0 = YW'(y0); c.x1 = XW'(x1); c.y1 = YW'(y1); c.color = CW'(col);
      return c;
   endfunction

   // Textbook integer Bresenham over the whole line, filtered by visibility.
   function automatic void build_ref(input lda_cmd_t c);
      int x, y, ex, ey, dx, dy, sx, sy, err, e2;
      exp_q.delete();
      x = int'(c.x0); y = int'(c.y0); ex = int'(c.x1); ey = int'(c.y1);
      dx = iabs(ex - x); dy = -iabs(ey - y);
      sx = (ex >= x) ? 1 : -1; sy = (ey >= y) ? 1 : -1;
      err = dx + dy;
      ref_len = 0;
      ref_first_on = visible(x, y);
      ref_last_on = visible(ex, ey);
      for (int n = 0; n < 2048; n++) begin
         ref_len++;
         if (visible(x, y)) exp_q.push_back('{x: x, y: y});
         if (x == ex && y == ey) break;
         e2 = 2 * err;
         if (e2 >= dy) begin err += dy; x += sx; end
         if (e2 <= dx) begin err += dx; y += sy; end
      end
   endfunction

   // mode: 0 sink always ready, 1 random ready, 2 ready pattern 1,0,0,...
   task automatic run_line(input lda_cmd_t c, input int mode, input int abort_at);
      int hs_cnt, pat, cyc, exp_cnt;
      bit stalled, done_seen, last_hs, saw_done;
      logic [XW-1:0] px, last_x;
      logic [YW-1:0] py, last_y;
      logic [CW-1:0] pc;
      pt_t p;
      build_ref(c);
      exp_cnt = ((iabs(int'(c.x1) - int'(c.x0)) > iabs(int'(c.y1) - int'(c.y0))) ?
                 iabs(int'(c.x1) - int'(c.x0)) : iabs(int'(c.y1) - int'(c.y0))) + 1;
      for (int t = 0; t < 8 && !cmd_ready; t++) @(negedge clk);
      chk("cmd_ready_idle", cmd_ready, 1);
      X0 = c.x0; Y0 = c.y0; X1 = c.x1; Y1 = c.y1; COLOR = c.color;
      cmd_valid = 1'b1; i_ready = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("accept_ready_busy", {cmd_ready, o_busy}, 2'b01);
      chk("first_valid", o_valid, ref_first_on);
      hs_cnt = 0; pat = 0; stalled = 0; done_seen = 0; last_hs = 0;
      px = '0; py = '0; pc = '0; last_x = '0; last_y = '0;
      for (cyc = 0; cyc < 4 * ref_len + 20; cyc++) begin
         if (o_done) begin
            chk("done_after_last_hs", last_hs, ref_last_on);
            chk("pixels_left", exp_q.size(), 0);
            if (mode == 0) chk("done_cycle", cyc, ref_len);
`ifndef LDA_CLIP_EN
            chk("pixel_count", hs_cnt, exp_cnt);
            chk("last_is_endpoint", {last_x, last_y}, {c.x1, c.y1});
`endif
            done_seen = 1;
            break;
         end
         if (stalled) chk("stall_hold", {o_valid, o_X, o_Y, o_COLOR}, {1'b1, px, py, pc});
         case (mode)
            0:       i_ready = 1'b1;
            1:       i_ready = 1'($urandom_range(0, 1));
            default: i_ready = (pat % 3 == 0);
         endcase
         pat++;
         if (hs_cnt == abort_at && o_valid) begin
            i_abort = 1'b1;
            @(negedge clk);
            i_abort = 1'b0; i_ready = 1'b0;
            chk("abort_idle", {o_valid, o_busy, cmd_ready, o_done}, 4'b0010);
            saw_done = 0;
            for (int k = 0; k < 4; k++) begin
               if (o_done) saw_done = 1;
               @(negedge clk);
            end
            chk("abort_no_done", saw_done, 0);
            return;
         end
         last_hs = o_valid && i_ready;
         if (last_hs) begin
            if (exp_q.size() == 0) chk("extra_pixel", exp_q.size(), 1);
            else begin
               p = exp_q.pop_front();
               chk("pixel_xyc", {o_X, o_Y, o_COLOR}, {XW'(p.x), YW'(p.y), c.color});
            end
            last_x = o_X; last_y = o_Y;
            hs_cnt++;
         end
         stalled = o_valid && !i_ready;
         px = o_X; py = o_Y; pc = o_COLOR;
         @(negedge clk);
      end
      i_ready = 1'b0;
      if (!done_seen) chk("done_timeout", done_seen, 1);
      else begin
         @(negedge clk);
         chk("post_done_idle", {o_done, o_valid, o_busy, cmd_ready}, 4'b0001);
      end
   endtask

   task automatic reset_mid_line();
      lda_cmd_t c;
      c = mk(0, 0, 20, 0, 5);
      X0 = c.x0; Y0 = c.y0; X1 = c.x1; Y1 = c.y1; COLOR = c.color;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0; i_ready = 1'b1;
      repeat (4) @(negedge clk);
      chk("mid_line_busy", {o_busy, o_valid}, 2'b11);
      #2 reset = 1'b0;
      #1;
      chk("async_reset_outputs", {o_valid, o_done, o_busy, cmd_ready, o_X, o_Y, o_COLOR},
          {4'b0001, {(XW+YW+CW){1'b0}}});
      @(negedge clk);
      reset = 1'b1; i_ready = 1'b0;
      @(negedge clk);
      chk("post_reset_idle", {o_done, o_valid, o_busy, cmd_ready}, 4'b0001);
   endtask

   initial begin
      #12;
      chk("reset_state", {o_valid, o_done, o_busy, cmd_ready, o_X, o_Y, o_COLOR},
          {4'b0001, {(XW+YW+CW){1'b0}}});
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      run_line(mk(0, 0, 4, 0, 3), 0, -1);
      run_line(mk(10, 10, 7, 2, 6), 0, -1);
      run_line(mk(0, 0, 3, 3, 1), 2, -1);
      run_line(mk(5, 5, 5, 5, 7), 0, -1);
      run_line(mk(0, 0, 20, 0, 2), 0, 2);
      run_line(mk(2, 9, 6, 1, 4), 0, -1);
      run_line(mk(318, 0, 322, 0, 5), 0, -1);
      run_line(mk(316, 237, 323, 244, 3), 1, -1);

      for (int i = 0; i < 30; i++)
         run_line(mk($urandom_range(0, 400), $urandom_range(0, 300),
                     $urandom_range(0, 400), $urandom_range(0, 300),
                     $urandom_range(0, 7)), (i % 5 == 0) ? 0 : 1, -1);

      reset_mid_line();
      run_line(mk(7, 3, 1, 8, 6), 1, -1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
